// File: rtl/posi_mpm_rate_est_pkg.sv
// Shared constants for the intra-mode rate estimator: PU sizes, special modes, bit costs, lambda table.
// Pure definitions; no latency and no flow control.
package posi_mpm_rate_est_pkg;

   typedef enum logic [1:0] {
      SIZE_04 = 2'd0,
      SIZE_08 = 2'd1,
      SIZE_16 = 2'd2,
      SIZE_32 = 2'd3
   } pu_size_e;

   localparam logic [5:0] INVALID_MODE = 6'h3F;
   localparam logic [5:0] MODE_PLANAR  = 6'd0;
   localparam logic [5:0] MODE_DC      = 6'd1;
   localparam logic [5:0] MODE_VER     = 6'd26;
   localparam logic [5:0] MODE_MAX     = 6'd34;

   localparam logic [2:0] BITS_IDX0 = 3'd2;
   localparam logic [2:0] BITS_IDX1 = 3'd3;
   localparam logic [2:0] BITS_IDX2 = 3'd3;
   localparam logic [2:0] BITS_MISS = 3'd6;
   localparam logic [1:0] IDX_MISS  = 2'd3;

   // round(2^((qp-12)/6)), floored at 1 for low QP; out-of-range QP yields 0
   function automatic logic [6:0] lambda_of_qp(input logic [5:0] qp);
      logic [6:0] l;
      if (qp <= 6'd15) begin
         l = 7'd1;
      end else begin
         case (qp)
            6'd16, 6'd17, 6'd18, 6'd19: l = 7'd2;
            6'd20, 6'd21, 6'd22:        l = 7'd3;
            6'd23, 6'd24, 6'd25:        l = 7'd4;
            6'd26:                      l = 7'd5;
            6'd27, 6'd28:               l = 7'd6;
            6'd29:                      l = 7'd7;
            6'd30:                      l = 7'd8;
            6'd31:                      l = 7'd9;
            6'd32:                      l = 7'd10;
            6'd33:                      l = 7'd11;
            6'd34:                      l = 7'd13;
            6'd35:                      l = 7'd14;
            6'd36:                      l = 7'd16;
            6'd37:                      l = 7'd18;
            6'd38:                      l = 7'd20;
            6'd39:                      l = 7'd23;
            6'd40:                      l = 7'd25;
            6'd41:                      l = 7'd29;
            6'd42:                      l = 7'd32;
            6'd43:                      l = 7'd36;
            6'd44:                      l = 7'd40;
            6'd45:                      l = 7'd45;
            6'd46:                      l = 7'd51;
            6'd47:                      l = 7'd57;
            6'd48:                      l = 7'd64;
            6'd49:                      l = 7'd72;
            6'd50:                      l = 7'd81;
            6'd51:                      l = 7'd91;
            default:                    l = 7'd0;
         endcase
      end
      return l;
   endfunction

endpackage

// File: rtl/posi_mpm_rate_est_if.sv
// Request/commit/result bundle between the mode-cost engine, the rate estimator and the RD compare.
// No handshake: requests and commits are strobes, results appear two cycles after a request.
interface posi_mpm_rate_est_if #(
   parameter int LCU_LOG2 = 6,
   parameter int MODE_W   = 6,
   parameter int RATE_W   = 13
);
   localparam int POS_W = 2 * (LCU_LOG2 - 2);

   logic [5:0]        qp_i;
   logic              lcu_start_i;
   logic              lcu_x_first_i;
   logic              req_valid_i;
   logic [MODE_W-1:0] req_mode_i;
   logic [1:0]        req_size_i;
   logic [POS_W-1:0]  req_pos_i;
   logic              cmt_valid_i;
   logic [MODE_W-1:0] cmt_mode_i;
   logic [1:0]        cmt_size_i;
   logic [POS_W-1:0]  cmt_pos_i;
   logic              rate_valid_o;
   logic [1:0]        mpm_idx_o;
   logic [RATE_W-1:0] bitrate_o;

   modport master (
      output qp_i, lcu_start_i, lcu_x_first_i,
      output req_valid_i, req_mode_i, req_size_i, req_pos_i,
      output cmt_valid_i, cmt_mode_i, cmt_size_i, cmt_pos_i,
      input  rate_valid_o, mpm_idx_o, bitrate_o
   );

   modport slave (
      input  qp_i, lcu_start_i, lcu_x_first_i,
      input  req_valid_i, req_mode_i, req_size_i, req_pos_i,
      input  cmt_valid_i, cmt_mode_i, cmt_size_i, cmt_pos_i,
      output rate_valid_o, mpm_idx_o, bitrate_o
   );

endinterface

// File: rtl/posi_mpm_rate_est_mpm.sv
// HEVC 3-entry MPM list from left (A) and top (B) neighbour modes; INVALID must already be mapped to DC.
// Purely combinational, no flow control.
module posi_mpm_derive #(
   parameter int MODE_W = 6
) (
   input  logic [MODE_W-1:0] a,
   input  logic [MODE_W-1:0] b,
   output logic [MODE_W-1:0] mpm0,
   output logic [MODE_W-1:0] mpm1,
   output logic [MODE_W-1:0] mpm2
);
   import posi_mpm_rate_est_pkg::*;

   localparam logic [MODE_W-1:0] PLANAR = MODE_W'(MODE_PLANAR);
   localparam logic [MODE_W-1:0] DC     = MODE_W'(MODE_DC);
   localparam logic [MODE_W-1:0] VER    = MODE_W'(MODE_VER);

   logic [4:0] a_p29;
   logic [4:0] a_m1;

   // angular neighbours wrap modulo 32 inside the 2..33 angular range
   assign a_p29 = a[4:0] + 5'd29;
   assign a_m1  = a[4:0] - 5'd1;

   always_comb begin
      mpm0 = a;
      mpm1 = b;
      mpm2 = PLANAR;
      if (a == b) begin
         if (a < MODE_W'(2)) begin
            mpm0 = PLANAR;
            mpm1 = DC;
            mpm2 = VER;
         end else begin
            mpm1 = MODE_W'(2) + MODE_W'(a_p29);
            mpm2 = MODE_W'(2) + MODE_W'(a_m1);
         end
      end else if (a != PLANAR && b != PLANAR) begin
         mpm2 = PLANAR;
      end else if (a != DC && b != DC) begin
         mpm2 = DC;
      end else begin
         mpm2 = VER;
      end
   end

endmodule

// File: rtl/posi_mpm_rate_est.sv
// Lambda-weighted intra mode bits from MPM membership using 4x4-granular neighbour buffers.
// Latency 2 cycles, one request per cycle, no backpressure.
module posi_mpm_rate_est #(
   parameter int LCU_LOG2 = 6,
   parameter int MODE_W   = 6,
   parameter int RATE_W   = 13
) (
   input  logic                  clk,
   input  logic                  rstn,
   posi_mpm_rate_est_if.slave    bus
);
   import posi_mpm_rate_est_pkg::*;

   localparam int XW    = LCU_LOG2 - 2;
   localparam int N4    = 1 << XW;
   localparam int POS_W = 2 * XW;

   localparam logic [MODE_W-1:0] INV = MODE_W'(INVALID_MODE);
   localparam logic [MODE_W-1:0] DC  = MODE_W'(MODE_DC);

   function automatic logic [POS_W-1:0] align_pos(input logic [POS_W-1:0] pos, input logic [1:0] size);
      logic [POS_W-1:0] low;
      low = (POS_W'(1) << {size, 1'b0}) - POS_W'(1);
      return pos & ~low;
   endfunction

   // z-scan de-interleave: even pos bits form x, odd pos bits form y
   function automatic logic [XW-1:0] pick(input logic [POS_W-1:0] pos, input int odd);
      logic [XW-1:0] r;
      for (int i = 0; i < XW; i++) r[i] = pos[2*i + odd];
      return r;
   endfunction

   logic [MODE_W-1:0] top_buf [N4];
   logic [MODE_W-1:0] lft_buf [N4];

   logic [XW-1:0]     req_x, req_y, cmt_x, cmt_y;
   logic [MODE_W-1:0] lft_rd, top_rd, nb_a, nb_b;
   logic [MODE_W-1:0] mpm0, mpm1, mpm2;
   logic [1:0]        hit_idx;
   logic [2:0]        hit_bits;
   logic [N4-1:0]     top_wr, lft_wr;

   logic              s1_vld;
   logic [1:0]        s1_idx;
   logic [2:0]        s1_bits;
   logic [6:0]        s1_lambda;
   logic [9:0]        prod;

   assign req_x = pick(align_pos(bus.req_pos_i, bus.req_size_i), 0);
   assign req_y = pick(align_pos(bus.req_pos_i, bus.req_size_i), 1);
   assign cmt_x = pick(align_pos(bus.cmt_pos_i, bus.cmt_size_i), 0);
   assign cmt_y = pick(align_pos(bus.cmt_pos_i, bus.cmt_size_i), 1);

   // the above-LCU row is not buffered and always counts as DC
   always_comb begin
      lft_rd = lft_buf[req_y];
      top_rd = top_buf[req_x];
      nb_a   = (lft_rd == INV) ? DC : lft_rd;
      nb_b   = (req_y == '0 || top_rd == INV) ? DC : top_rd;
   end

   posi_mpm_derive #(.MODE_W(MODE_W)) u_derive (
      .a    (nb_a),
      .b    (nb_b),
      .mpm0 (mpm0),
      .mpm1 (mpm1),
      .mpm2 (mpm2)
   );

   always_comb begin
      hit_idx  = IDX_MISS;
      hit_bits = BITS_MISS;
      if (bus.req_mode_i <= MODE_W'(MODE_MAX)) begin
         if (bus.req_mode_i == mpm0) begin
            hit_idx  = 2'd0;
            hit_bits = BITS_IDX0;
         end else if (bus.req_mode_i == mpm1) begin
            hit_idx  = 2'd1;
            hit_bits = BITS_IDX1;
         end else if (bus.req_mode_i == mpm2) begin
            hit_idx  = 2'd2;
            hit_bits = BITS_IDX2;
         end
      end
   end

   // span compares in int so edges past N4-1 simply never match
   always_comb begin
      int span;
      span = 1 << bus.cmt_size_i;
      for (int i = 0; i < N4; i++) begin
         top_wr[i] = (i >= int'(cmt_x)) && (i < int'(cmt_x) + span);
         lft_wr[i] = (i >= int'(cmt_y)) && (i < int'(cmt_y) + span);
      end
   end

   // commit is written after the LCU clear so a same-cycle commit survives
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N4; i++) begin
            top_buf[i] <= INV;
            lft_buf[i] <= INV;
         end
      end else begin
         for (int i = 0; i < N4; i++) begin
            if (bus.lcu_start_i)                      top_buf[i] <= INV;
            if (bus.lcu_start_i && bus.lcu_x_first_i) lft_buf[i] <= INV;
            if (bus.cmt_valid_i && top_wr[i])         top_buf[i] <= bus.cmt_mode_i;
            if (bus.cmt_valid_i && lft_wr[i])         lft_buf[i] <= bus.cmt_mode_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_vld    <= 1'b0;
         s1_idx    <= IDX_MISS;
         s1_bits   <= '0;
         s1_lambda <= '0;
      end else begin
         s1_vld <= bus.req_valid_i;
         if (bus.req_valid_i) begin
            s1_idx    <= hit_idx;
            s1_bits   <= hit_bits;
            s1_lambda <= lambda_of_qp(bus.qp_i);
         end
      end
   end

   assign prod = {3'b000, s1_lambda} * {7'b0000000, s1_bits};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.rate_valid_o <= 1'b0;
         bus.mpm_idx_o    <= IDX_MISS;
         bus.bitrate_o    <= '0;
      end else begin
         bus.rate_valid_o <= s1_vld;
         if (s1_vld) begin
            bus.mpm_idx_o <= s1_idx;
            bus.bitrate_o <= RATE_W'(prod);
         end
      end
   end

endmodule

// File: tb/tb_posi_mpm_rate_est.sv
// Bench for posi_mpm_rate_est: table of neighbour-free vectors plus hand sequences for commits,
// LCU boundaries, same-cycle events and mid-flight reset; results checked through an expected queue.
module tb_posi_mpm_rate_est;
   import posi_mpm_rate_est_pkg::*;

   localparam int LCU_LOG2 = 6;
   localparam int MODE_W   = 6;
   localparam int RATE_W   = 13;

   typedef struct {
      logic [1:0] idx;
      int         rate;
      int         cyc;
   } exp_t;

   typedef struct {
      logic [5:0] mode;
      logic [1:0] size;
      logic [7:0] pos;
      logic [5:0] qp;
      logic [1:0] idx;
      int         rate;
   } vec_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   pushed = 0;
   int   popped = 0;
   exp_t sb[$];
   vec_t vecs[12];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   posi_mpm_rate_est_if #(.LCU_LOG2(LCU_LOG2), .MODE_W(MODE_W), .RATE_W(RATE_W)) bus();

   posi_mpm_rate_est #(.LCU_LOG2(LCU_LOG2), .MODE_W(MODE_W), .RATE_W(RATE_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.req_valid_i   = 1'b0;
      bus.cmt_valid_i   = 1'b0;
      bus.lcu_start_i   = 1'b0;
      bus.lcu_x_first_i = 1'b0;
   endtask

   task automatic set_req(input logic [5:0] mode, input logic [1:0] size, input logic [7:0] pos,
                          input logic [5:0] qp, input logic [1:0] idx, input int rate, input bit push);
      exp_t e;
      bus.req_valid_i = 1'b1;
      bus.req_mode_i  = mode;
      bus.req_size_i  = size;
      bus.req_pos_i   = pos;
      bus.qp_i        = qp;
      if (push) begin
         e.idx  = idx;
         e.rate = rate;
         e.cyc  = cyc + 2;
         sb.push_back(e);
         pushed++;
      end
   endtask

   task automatic set_cmt(input logic [5:0] mode, input logic [1:0] size, input logic [7:0] pos);
      bus.cmt_valid_i = 1'b1;
      bus.cmt_mode_i  = mode;
      bus.cmt_size_i  = size;
      bus.cmt_pos_i   = pos;
   endtask

   task automatic lcu_start(input logic x_first);
      bus.lcu_start_i   = 1'b1;
      bus.lcu_x_first_i = x_first;
   endtask

   initial begin
      bus.qp_i = '0;  bus.lcu_start_i = 1'b0; bus.lcu_x_first_i = 1'b0;
      bus.req_valid_i = 1'b0; bus.req_mode_i = '0; bus.req_size_i = '0; bus.req_pos_i = '0;
      bus.cmt_valid_i = 1'b0; bus.cmt_mode_i = '0; bus.cmt_size_i = '0; bus.cmt_pos_i = '0;

      // all buffers INVALID -> A = B = DC -> list {0, 1, 26}
      vecs[0]  = '{6'd1,  2'd1, 8'd0,   6'd32, 2'd1, 30};
      vecs[1]  = '{6'd0,  2'd0, 8'd5,   6'd26, 2'd0, 10};
      vecs[2]  = '{6'd26, 2'd2, 8'd0,   6'd51, 2'd2, 273};
      vecs[3]  = '{6'd10, 2'd0, 8'd3,   6'd51, 2'd3, 546};
      vecs[4]  = '{6'd35, 2'd0, 8'd9,   6'd32, 2'd3, 60};
      vecs[5]  = '{6'd63, 2'd0, 8'd0,   6'd0,  2'd3, 6};
      vecs[6]  = '{6'd1,  2'd3, 8'd0,   6'd52, 2'd1, 0};
      vecs[7]  = '{6'd0,  2'd0, 8'd200, 6'd15, 2'd0, 2};
      vecs[8]  = '{6'd26, 2'd1, 8'd12,  6'd7,  2'd2, 3};
      vecs[9]  = '{6'd34, 2'd0, 8'd77,  6'd26, 2'd3, 30};
      vecs[10] = '{6'd1,  2'd0, 8'd255, 6'd63, 2'd1, 0};
      vecs[11] = '{6'd0,  2'd1, 8'd16,  6'd51, 2'd0, 182};

      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clk);
               if (rstn === 1'b1 && bus.rate_valid_o === 1'b1) begin
                  if (sb.size() == 0) begin
                     check("unexpected_result", 1, 0);
                  end else begin
                     e = sb.pop_front();
                     popped++;
                     check("mpm_idx", 32'(bus.mpm_idx_o), 32'(e.idx));
                     check("bitrate", 32'(bus.bitrate_o), e.rate);
                     check("latency", cyc, e.cyc);
                  end
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("rst_rate_valid", 32'(bus.rate_valid_o), 0);
      check("rst_mpm_idx", 32'(bus.mpm_idx_o), 3);
      check("rst_bitrate", 32'(bus.bitrate_o), 0);
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         set_req(vecs[i].mode, vecs[i].size, vecs[i].pos, vecs[i].qp, vecs[i].idx, vecs[i].rate, 1);
         tick();
      end
      repeat (4) tick();
      check("hold_rate_valid", 32'(bus.rate_valid_o), 0);
      check("hold_mpm_idx", 32'(bus.mpm_idx_o), 32'(vecs[11].idx));
      check("hold_bitrate", 32'(bus.bitrate_o), vecs[11].rate);

      // left neighbour from commit, top row is DC
      set_cmt(10, 1, 0); tick();
      set_req(10, 1, 4, 51, 0, 182, 1); tick();

      // A = B = 18 -> {18, 17, 19}
      set_cmt(18, 2, 0); tick();
      set_req(5,  0, 10, 26, 3, 30, 1); tick();
      set_req(18, 0, 10, 26, 0, 10, 1); tick();
      set_req(17, 0, 10, 26, 1, 15, 1); tick();
      set_req(19, 0, 10, 26, 2, 15, 1); tick();

      // A = B = 2 wraps to {2, 33, 3}; unaligned 16x16 pos aligns to 0 -> {2, 1, 0}
      set_cmt(2, 3, 0); tick();
      set_req(33, 0, 10, 32, 1, 30, 1); tick();
      set_req(3,  0, 10, 32, 2, 30, 1); tick();
      set_req(1,  2, 15, 32, 1, 30, 1); tick();

      // A = 1, B = 0 -> {1, 0, 26}
      set_cmt(0, 0, 1); tick();
      set_cmt(1, 0, 2); tick();
      set_req(26, 0, 3, 32, 2, 30, 1); tick();
      set_req(0,  0, 3, 32, 1, 30, 1); tick();

      // same-cycle commit: old {1, 0, 26}, then A = B = 7 -> {7, 6, 8}
      set_cmt(7, 0, 3);
      set_req(26, 0, 3, 32, 2, 30, 1); tick();
      set_req(7,  0, 3, 32, 0, 20, 1); tick();

      // far corner x4 = y4 = 15: A = B = 30 -> {30, 29, 31}
      set_cmt(30, 3, 192); tick();
      set_req(31, 0, 255, 32, 2, 30, 1); tick();

      // new LCU in the same row keeps left column
      lcu_start(1'b0); tick();
      set_req(7, 0, 2, 32, 0, 20, 1); tick();
      // first LCU of a row clears everything
      lcu_start(1'b1); tick();
      set_req(7, 0, 2, 32, 3, 60, 1); tick();
      set_req(1, 0, 2, 32, 1, 30, 1); tick();

      // clear and commit in one cycle: commit wins on its entries
      lcu_start(1'b1); set_cmt(20, 0, 0); tick();
      set_req(20, 0, 1, 32, 0, 20, 1); tick();
      set_req(20, 0, 2, 32, 1, 30, 1); tick();
      repeat (4) tick();

      // reset with two requests in flight
      set_req(0, 0, 0, 32, 2, 30, 0); tick();
      set_req(0, 0, 0, 32, 2, 30, 0); tick();
      rstn = 1'b0;
      #1;
      check("midrst_rate_valid", 32'(bus.rate_valid_o), 0);
      check("midrst_mpm_idx", 32'(bus.mpm_idx_o), 3);
      check("midrst_bitrate", 32'(bus.bitrate_o), 0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (6) tick();
      set_req(20, 0, 1, 32, 3, 60, 1); tick();

      for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
      check("queue_drained", sb.size(), 0);
      check("result_count", popped, pushed);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
